ps2_keycode_filter: RTL and testbench

- Sits between ps2_controller and morse_code_encoder.
- Consumes raw PS/2 scan-code bytes (ps2_received_data + ps2_received_data_strb).
- Removes break sequences, extended prefixes, protocol/status bytes and optionally typematic repeats.
- Buffers the remaining make codes in a small FIFO and releases them one at a time to the encoder when it signals ready.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_keycode_filter_if.sv | 25 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/ps2_keycode_filter.sv | 123 ++++++++++++
 tb/tb_ps2_keycode_filter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and parser state encoding for the keycode filter.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERR0      = 8'h00;
  localparam logic [7:0] PS2_ERR1      = 8'hFF;
  localparam logic [7:0] PS2_BAT_FAIL0 = 8'hFC;
  localparam logic [7:0] PS2_BAT_FAIL1 = 8'hFD;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } parse_state_t;

  // Bytes the keyboard sends for protocol/status reasons, never key presses.
  function automatic logic is_status_byte(input logic [7:0] b);
    case (b)
      PS2_ERR0, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
      PS2_BAT_FAIL0, PS2_BAT_FAIL1, PS2_RESEND, PS2_ERR1: is_status_byte = 1'b1;
      default:                                            is_status_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keycode_filter_if.sv
// Byte-in / keycode-out signal bundle between ps2_controller, the filter and the encoder.
interface ps2_keycode_filter_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    ps2_received_data;
  logic          ps2_received_data_strb;
  logic          out_ready;
  logic [7:0]    keycode_data;
  logic          keycode_strb;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output ps2_received_data, ps2_received_data_strb, out_ready,
    input  keycode_data, keycode_strb, fifo_count, overflow
  );

  modport slave (
    input  ps2_received_data, ps2_received_data_strb, out_ready,
    output keycode_data, keycode_strb, fifo_count, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity, so
  // clearing them empties the FIFO and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode_filter.sv
// Strips break/extended/status bytes and typematic repeats from a PS/2 byte stream,
// buffering make codes and handing them to the encoder one at a time.
module ps2_keycode_filter #(
  parameter int FIFO_DEPTH      = 8,
  parameter bit PASS_EXTENDED   = 1'b0,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  ps2_keycode_filter_if.slave bus
);
  import ps2_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  parse_state_t  state, state_next;
  logic [7:0]    last_make, last_make_next;
  logic          last_valid, last_valid_next;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          dup;
  logic [7:0]    b;
  logic [7:0]    keycode_data;
  logic          keycode_strb;
  logic          overflow;

  assign b   = bus.ps2_received_data;
  assign dup = SUPPRESS_REPEAT && last_valid && (b == last_make);

  // NOTE: every output of this block is given a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    last_make_next  = last_make;
    last_valid_next = last_valid;
    push            = 1'b0;
    if (bus.ps2_received_data_strb) begin
      case (state)
        IDLE: begin
          if (b == PS2_BREAK)          state_next = BREAK;
          else if (b == PS2_EXT)       state_next = EXT;
          else if (!is_status_byte(b) && !dup) begin
            push            = 1'b1;
            last_make_next  = b;
            last_valid_next = 1'b1;
          end
        end
        BREAK: begin
          state_next = IDLE;
          if (b == last_make) last_valid_next = 1'b0;
        end
        EXT: begin
          if (b == PS2_BREAK)    state_next = EXT_BREAK;
          else if (b == PS2_EXT) state_next = EXT;
          else begin
            state_next = IDLE;
            if (PASS_EXTENDED && !dup) begin
              push            = 1'b1;
              last_make_next  = b;
              last_valid_next = 1'b1;
            end
          end
        end
        EXT_BREAK: begin
          state_next = IDLE;
          if (PASS_EXTENDED && (b == last_make)) last_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_make  <= 8'h00;
      last_valid <= 1'b0;
    end else begin
      state      <= state_next;
      last_make  <= last_make_next;
      last_valid <= last_valid_next;
    end
  end

  // Gating on the previous strobe forces an idle cycle between output strobes.
  assign pop = !empty && bus.out_ready && !keycode_strb;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (b),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycode_data <= 8'h00;
      keycode_strb <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      keycode_strb <= pop;
      if (pop) keycode_data <= head;
      overflow <= push && full && !pop;
    end
  end

  assign bus.keycode_data = keycode_data;
  assign bus.keycode_strb = keycode_strb;
  assign bus.fifo_count   = count;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_ps2_keycode_filter.sv
// Directed bench: two filters (extended bytes dropped / forwarded) driven with the same stream.
module tb_ps2_keycode_filter;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       strb;
  logic       ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovf0  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         t0[$];

  ps2_keycode_filter_if #(.FIFO_DEPTH(8)) bus0 ();
  ps2_keycode_filter_if #(.FIFO_DEPTH(8)) bus1 ();

  assign bus0.ps2_received_data      = data;
  assign bus0.ps2_received_data_strb = strb;
  assign bus0.out_ready              = ready;
  assign bus1.ps2_received_data      = data;
  assign bus1.ps2_received_data_strb = strb;
  assign bus1.out_ready              = ready;

  ps2_keycode_filter #(.FIFO_DEPTH(8), .PASS_EXTENDED(1'b0), .SUPPRESS_REPEAT(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  ps2_keycode_filter #(.FIFO_DEPTH(8), .PASS_EXTENDED(1'b1), .SUPPRESS_REPEAT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus0.keycode_strb) begin
      q0.push_back(bus0.keycode_data);
      t0.push_back(cyc);
    end
    if (bus1.keycode_strb) q1.push_back(bus1.keycode_data);
    if (bus0.overflow) ovf0++;
  end

  typedef struct {
    logic [7:0] data;
    logic       strb;
    logic       ready;
    logic       exp_strb;
    logic [7:0] exp_data;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    strb = 1'b1;
    step();
    strb = 1'b0;
    data = 8'h00;
  endtask

  task automatic clear_queues();
    q0.delete();
    q1.delete();
    t0.delete();
  endtask

  initial begin
    rst   = 1'b1;
    data  = 8'h00;
    strb  = 1'b0;
    ready = 1'b1;

    //               data   s     r     es    edata  ecnt
    vecs[0]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1};
    vecs[1]  = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'h1C, 4'd0};
    vecs[2]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C, 4'd0};
    vecs[3]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'h1C, 4'd0};
    vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h1C, 4'd0};
    vecs[5]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C, 4'd1};
    vecs[6]  = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 4'd0};
    vecs[7]  = '{8'h32, 1'b1, 1'b0, 1'b0, 8'h1C, 4'd1};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd1};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h32, 4'd0};
    vecs[10] = '{8'h21, 1'b1, 1'b1, 1'b0, 8'h32, 4'd1};
    vecs[11] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h21, 4'd1};
    vecs[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 4'd1};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 4'd0};
    vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 4'd0};

    // Reset values while rst is held.
    #12;
    check("reset_strb",  32'(bus0.keycode_strb), 32'd0);
    check("reset_data",  32'(bus0.keycode_data), 32'h00);
    check("reset_count", 32'(bus0.fifo_count),   32'd0);
    check("reset_ovf",   32'(bus0.overflow),     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cycle-exact vectors: make/break, status bytes, bubble latency, held output.
    for (int i = 0; i < 15; i++) begin
      data  = vecs[i].data;
      strb  = vecs[i].strb;
      ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_dut0", i),
            {19'd0, bus0.keycode_strb, bus0.keycode_data, bus0.fifo_count},
            {19'd0, vecs[i].exp_strb, vecs[i].exp_data, vecs[i].exp_count});
      check($sformatf("vec%0d_dut1", i),
            {19'd0, bus1.keycode_strb, bus1.keycode_data, bus1.fifo_count},
            {19'd0, vecs[i].exp_strb, vecs[i].exp_data, vecs[i].exp_count});
    end
    strb = 1'b0;
    ready = 1'b1;
    idle(2);

    // Typematic repeats suppressed until the break.
    clear_queues();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(6);
    check("repeat_n",  32'(q0.size()), 32'd2);
    check("repeat_q0", 32'(q0[0]), 32'h1C);
    check("repeat_q1", 32'(q0[1]), 32'h1C);

    // Extended make/break, then status bytes, then a plain make to prove IDLE.
    clear_queues();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA); send(8'h29);
    idle(6);
    check("ext0_n",    32'(q0.size()), 32'd1);
    check("ext0_code", 32'(q0[0]), 32'h29);
    check("ext1_n",    32'(q1.size()), 32'd2);
    check("ext1_code", 32'(q1[0]), 32'h75);
    check("ext1_next", 32'(q1[1]), 32'h29);

    // Overflow: ten codes into an 8-deep FIFO with the encoder stalled.
    clear_queues();
    ovf0  = 0;
    ready = 1'b0;
    for (int k = 0; k < 10; k++) send(8'h15 + 8'(k));
    idle(1);
    check("ovf_count", 32'(bus0.fifo_count), 32'd8);
    check("ovf_pulses", 32'(ovf0), 32'd2);
    check("ovf_held",  32'(q0.size()), 32'd0);
    ready = 1'b1;
    idle(24);
    check("drain_n", 32'(q0.size()), 32'd8);
    for (int k = 0; k < 8; k++) check($sformatf("drain_%0d", k), 32'(q0[k]), 32'h15 + 32'(k));
    for (int k = 1; k < 8; k++)
      check($sformatf("gap_%0d", k), 32'((t0[k] - t0[k-1]) >= 2), 32'd1);
    check("drain_empty", 32'(bus0.fifo_count), 32'd0);

    // Push into a full FIFO on the same edge as a pop.
    clear_queues();
    ovf0  = 0;
    ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'h40 + 8'(k));
    check("full_count", 32'(bus0.fifo_count), 32'd8);
    ready = 1'b1;
    send(8'h48);
    check("pp_count", 32'(bus0.fifo_count), 32'd8);
    check("pp_strb",  32'(bus0.keycode_strb), 32'd1);
    check("pp_ovf",   32'(bus0.overflow), 32'd0);
    idle(24);
    check("pp_ovf_n", 32'(ovf0), 32'd0);
    check("pp_n",     32'(q0.size()), 32'd9);
    check("pp_first", 32'(q0[0]), 32'h40);
    check("pp_last",  32'(q0[8]), 32'h48);

    // Asynchronous reset with codes buffered and the parser inside a break.
    clear_queues();
    ready = 1'b0;
    send(8'h50); send(8'h51); send(8'h52); send(8'hF0);
    check("pre_rst_count", 32'(bus0.fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_count", 32'(bus0.fifo_count), 32'd0);
    check("async_strb",  32'(bus0.keycode_strb), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    send(8'h1C);
    idle(4);
    check("post_rst_n",    32'(q0.size()), 32'd1);
    check("post_rst_code", 32'(q0[0]), 32'h1C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
